hamming_secded_encoder: RTL and testbench
=========================================

Name: hamming_secded_encoder

Overview:
- Upstream stage of the 32-bit Hamming SECDED decoder.
- Accepts 26-bit data words over a valid/ready handshake and computes 5 Hamming check bits plus 1 overall parity bit.
- Emits registered 32-bit codewords whose 6-bit syndrome, XOR-ed at the decoder, is zero for an error-free word.
- Two-stage pipeline with full back-pressure, plus a saturating count of emitted words.

Parameters:
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  data_in holds a valid word.
- in_ready  output  1  block accepts a word this cycle.
- data_in  input  26  payload.
- out_valid  output  1  code_out holds a valid codeword.
- out_ready  input  1  downstream consumes the codeword this cycle.
- code_out  output  32  SECDED codeword.
- word_cnt  output  CNT_W  number of codewords accepted downstream, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Codeword map:
  - code_out[i] for i=1..31 is Hamming position i.
  - Check bits sit at positions 1, 2, 4, 8, 16.
  - Data fills the remaining positions 3,5,6,7,9..15,17..31 in ascending order; data_in[0] goes to position 3 and data_in[25] to position 31.
- Check bit at position 2^k = XOR of all data positions i (i != 2^k) with bit k of i set.
- code_out[0] = XOR of code_out[31:1], so the full 32-bit word has even parity.
- Pipeline:
  - S1 registers data_in and s1_valid.
  - S2 computes the parity bits combinationally from the S1 data and registers the full codeword into code_out and out_valid.
  - Latency is 2 cycles from in_valid&&in_ready to out_valid with no stall.
  - Throughput is 1 word/cycle.
- Advance condition: adv = !out_valid || out_ready.
  - S2 loads from S1 when adv is true.
  - out_valid_next = s1_valid when adv is true, otherwise out_valid holds.
- in_ready = !s1_valid || adv. It is combinational from out_ready; it has no dependence on in_valid.
- S1 loads when in_valid && in_ready. s1_valid_next = in_valid when in_ready is true, otherwise s1_valid holds.
- Stall: when out_valid && !out_ready, code_out and out_valid hold, and S1 holds its word.
  - Once S1 is also full, in_ready=0 and no word is lost or duplicated.
- Simultaneous events: with both stages full and out_ready=1, S2 takes S1 and S1 takes the new input in the same cycle.
- word_cnt increments on each out_valid && out_ready and saturates at 2^CNT_W-1. It does not wrap.
- Reset values: s1_valid=0, out_valid=0, code_out=0, word_cnt=0. in_ready reads 1 during and after reset.
- Reset mid-operation discards all in-flight words. No out_valid pulse follows reset until new input is accepted.
- code_out is don't-care when out_valid=0, but it must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: HAMMING_ERR_INJECT_EN.
- With the macro defined:
  - Adds input inj_en (1 bit) and input inj_pos (5 bits).
  - When S2 loads a word while inj_en=1, bit inj_pos of the computed codeword is inverted before registration.
  - inj_pos=0 flips the overall parity bit.
  - A counter inj_cnt (output, CNT_W bits, saturating, reset 0) increments per injected word.
  - Used to exercise decoder single-error correction.
- Without the macro: inj_en, inj_pos and inj_cnt do not exist, and the codeword is always clean.

Test Plan:
- Reset, then data_in=26'h0000000 with in_valid=1 for 1 cycle and out_ready=1 -> out_valid=1 exactly 2 cycles later with code_out=32'h00000000. word_cnt=1.
- data_in=26'h0000001 -> code_out=32'h0000000F (positions 1,2,3 and overall parity set).
- data_in=26'h3FFFFFF -> code_out=32'hFFFFFFFF. The 6-bit XOR of the set positions is 0.
- Stream 8 random words with out_ready=0 for cycles 3-6 -> in_ready drops once both stages are full. All 8 codewords appear in order with no loss or duplication, each matching a reference model. word_cnt=8.
- Assert rst for 1 cycle with 2 words in flight -> next cycle out_valid=0 and word_cnt=0. No stale word is emitted afterwards.
- With HAMMING_ERR_INJECT_EN: inj_en=1, inj_pos=5, data_in=26'h0000000 -> code_out=32'h00000020, the decoder reports error position 5, and inj_cnt=1.

Source files
------------

// File: rtl/hamming_secded_encoder.sv
// Two-stage valid/ready SECDED encoder: 26 data bits -> 32-bit codeword (Hamming positions 1..31, overall parity at bit 0).
// Optional build macro HAMMING_ERR_INJECT_EN adds single-bit fault injection (inj_en, inj_pos, inj_cnt).
module hamming_secded_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [25:0]      data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      code_out,
    output logic [CNT_W-1:0] word_cnt
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic             inj_en,
    input  logic [4:0]       inj_pos,
    output logic [CNT_W-1:0] inj_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Scatter data into non-power-of-two positions, then fill check bits and overall parity.
    function automatic logic [31:0] secded_encode(input logic [25:0] d);
        logic [31:0] c;
        logic        p;
        int          j;
        c = 32'h0000_0000;
        j = 0;
        for (int i = 3; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            p = 1'b0;
            for (int i = 3; i < 32; i++) begin
                if ((((i >> k) & 1) == 1) && (i != (1 << k))) begin
                    p = p ^ c[i];
                end
            end
            c[1 << k] = p;
        end
        c[0] = ^c[31:1];
        return c;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [25:0]      s1_data_q,  s1_data_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      code_q,     code_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             adv_s;
    logic             in_ready_s;
    logic [31:0]      enc_s;
    logic [31:0]      flip_s;
    logic             inj_hit_s;
`ifdef HAMMING_ERR_INJECT_EN
    logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;
`endif

    assign adv_s      = !out_valid_q || out_ready;
    assign in_ready_s = !s1_valid_q || adv_s;
    assign enc_s      = secded_encode(s1_data_q);

`ifdef HAMMING_ERR_INJECT_EN
    assign inj_hit_s = inj_en;
    assign flip_s    = inj_en ? (32'h0000_0001 << inj_pos) : 32'h0000_0000;
`else
    assign inj_hit_s = 1'b0;
    assign flip_s    = 32'h0000_0000;
`endif

    // Next-state logic for both pipeline stages and the counters.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        code_d      = code_q;
        word_cnt_d  = word_cnt_q;
`ifdef HAMMING_ERR_INJECT_EN
        inj_cnt_d   = inj_cnt_q;
`endif
        if (in_ready_s) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (in_valid && in_ready_s) begin
            s1_data_d = data_in;
        end else begin
            s1_data_d = s1_data_q;
        end
        if (adv_s) begin
            out_valid_d = s1_valid_q;
            code_d      = enc_s ^ flip_s;
        end else begin
            out_valid_d = out_valid_q;
            code_d      = code_q;
        end
        if (out_valid_q && out_ready && (word_cnt_q != CNT_MAX)) begin
            word_cnt_d = word_cnt_q + CNT_ONE;
        end else begin
            word_cnt_d = word_cnt_q;
        end
`ifdef HAMMING_ERR_INJECT_EN
        if (adv_s && s1_valid_q && inj_hit_s && (inj_cnt_q != CNT_MAX)) begin
            inj_cnt_d = inj_cnt_q + CNT_ONE;
        end else begin
            inj_cnt_d = inj_cnt_q;
        end
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= 26'h000_0000;
            out_valid_q <= 1'b0;
            code_q      <= 32'h0000_0000;
            word_cnt_q  <= {CNT_W{1'b0}};
`ifdef HAMMING_ERR_INJECT_EN
            inj_cnt_q   <= {CNT_W{1'b0}};
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            word_cnt_q  <= word_cnt_d;
`ifdef HAMMING_ERR_INJECT_EN
            inj_cnt_q   <= inj_cnt_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign code_out  = code_q;
    assign word_cnt  = word_cnt_q;
`ifdef HAMMING_ERR_INJECT_EN
    assign inj_cnt   = inj_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_secded_encoder.sv
// Directed self-checking bench for hamming_secded_encoder; define HAMMING_ERR_INJECT_EN to also cover fault injection.
module tb_hamming_secded_encoder;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [25:0]      data_in;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      code_out;
    logic [CNT_W-1:0] word_cnt;
`ifdef HAMMING_ERR_INJECT_EN
    logic             inj_en;
    logic [4:0]       inj_pos;
    logic [CNT_W-1:0] inj_cnt;
`endif

    int n_assert;
    int n_fail;

    int          dpos [26] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20,
                               21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31};
    logic [25:0] vec  [8]  = '{26'h2AA_AAAA, 26'h155_5555, 26'h000_0002, 26'h200_0000,
                               26'h012_3456, 26'h3FE_DCBA, 26'h0F0_F0F0, 26'h30C_30C3};

    hamming_secded_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_out  (code_out),
        .word_cnt  (word_cnt)
`ifdef HAMMING_ERR_INJECT_EN
        ,
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
        .inj_cnt   (inj_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference codeword: scatter via position table, check bits via position-class masks.
    function automatic logic [31:0] ref_code(input logic [25:0] d);
        logic [31:0] c;
        c = 32'h0000_0000;
        for (int i = 0; i < 26; i++) c[dpos[i]] = d[i];
        c[1]  = ^(c & 32'hAAAA_AAAA);
        c[2]  = ^(c & 32'hCCCC_CCCC);
        c[4]  = ^(c & 32'hF0F0_F0F0);
        c[8]  = ^(c & 32'hFF00_FF00);
        c[16] = ^(c & 32'hFFFF_0000);
        c[0]  = ^c[31:1];
        return c;
    endfunction

    function automatic logic [4:0] syndrome(input logic [31:0] c);
        logic [4:0] s;
        s = 5'd0;
        for (int i = 1; i < 32; i++) if (c[i]) s = s ^ 5'(i);
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [25:0] d, input logic [31:0] exp_code,
                            input logic [31:0] exp_cnt);
        data_in  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_code"}, code_out, exp_code);
        step();
        check({tag, "_cnt"}, {16'd0, word_cnt}, exp_cnt);
        check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_q [$];
        logic [31:0] held;
        logic        hold_v;
        logic        idle_ok;
        int          sent;
        int          rcvd;

        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = 26'h000_0000;
`ifdef HAMMING_ERR_INJECT_EN
        inj_en    = 1'b0;
        inj_pos   = 5'd0;
`endif
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_code", code_out, 32'h0000_0000);
        check("rst_cnt", {16'd0, word_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        send_one("zero", 26'h000_0000, 32'h0000_0000, 32'd1);
        send_one("one",  26'h000_0001, 32'h0000_000F, 32'd2);
        send_one("ones", 26'h3FF_FFFF, 32'hFFFF_FFFF, 32'd3);
        check("ones_syn", {27'd0, syndrome(32'hFFFF_FFFF)}, 32'd0);

        // Streaming with a downstream stall on cycles 3..6.
        rst = 1'b1;
        step();
        rst = 1'b0;
        sent   = 0;
        rcvd   = 0;
        hold_v = 1'b0;
        held   = 32'h0000_0000;
        for (int c = 0; c < 60 && rcvd < 8; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 8);
            data_in   = (sent < 8) ? vec[sent] : 26'h000_0000;
            #1;
            if (c <= 7) check("stream_in_ready", {31'd0, in_ready}, (c >= 3 && c <= 6) ? 32'd0 : 32'd1);
            if (hold_v) check("stall_hold", code_out, held);
            hold_v = out_valid && !out_ready;
            held   = code_out;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    check("stream_word", code_out, exp_q.pop_front());
                end else begin
                    check("stream_dup", 32'd1, 32'd0);
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_code(vec[sent]));
                sent++;
            end
            step();
        end
        in_valid = 1'b0;
        check("stream_rcvd", 32'(rcvd), 32'd8);
        check("stream_cnt", {16'd0, word_cnt}, 32'd8);
        check("stream_idle", {31'd0, out_valid}, 32'd0);

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 26'h155_5555;
        step();
        data_in   = 26'h2AA_AAAA;
        step();
        in_valid  = 1'b0;
        #1;
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_cnt", {16'd0, word_cnt}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        idle_ok   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid !== 1'b0) idle_ok = 1'b0;
        end
        check("midrst_no_stale", {31'd0, idle_ok}, 32'd1);

`ifdef HAMMING_ERR_INJECT_EN
        inj_en   = 1'b1;
        inj_pos  = 5'd5;
        data_in  = 26'h000_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        inj_en   = 1'b0;
        check("inj_code", code_out, 32'h0000_0020);
        check("inj_syn", {27'd0, syndrome(code_out)}, 32'd5);
        check("inj_par", {31'd0, ^code_out}, 32'd1);
        check("inj_cnt", {16'd0, inj_cnt}, 32'd1);
        step();
`endif

        // Saturation of the emitted-word counter.
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = 26'h012_3456;
        for (int i = 0; i < 65540; i++) step();
        in_valid = 1'b0;
        check("sat_cnt", {16'd0, word_cnt}, {16'd0, {CNT_W{1'b1}}});
        step();
        step();
        check("sat_hold", {16'd0, word_cnt}, {16'd0, {CNT_W{1'b1}}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
